// File: rtl/led_smpl_seq.sv
// led_smpl_seq: collects sporadic codec samples into a frame buffer, then replays
// the whole frame as one back-to-back burst (sequencing/smpl_out) for the LED
// averager, followed by a guard gap.
// Optional feature macro LED_SEQ_ABS_EN: smpl_out carries |x| (with -32768
// saturating to 32767) instead of the raw signed sample.
module led_smpl_seq #(
    parameter int BURST_LEN = 1024,
    parameter int AW        = 10,
    parameter int GAP_CYC   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        smpl_vld,
    input  logic [15:0] smpl_in,
    output logic        sequencing,
    output logic [15:0] smpl_out,
    output logic        frm_done,
    output logic [7:0]  drop_cnt
);

    // One extra counter bit keeps the terminal-count compare from wrapping.
    localparam int CW = AW + 1;
    localparam int IW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(BURST_LEN - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

    typedef enum logic [1:0] {IDLE, FILL, BURST, GAP} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  wr_cnt;
    logic [CW-1:0]  rd_cnt;
    logic [GW-1:0]  gap_cnt;
    logic           wr_en;
    logic           rd_en;
    logic           fill_last;
    logic           burst_last;
    logic           gap_last;
    logic [15:0]    mem [0:BURST_LEN-1];
    logic [15:0]    rd_data;
    logic [15:0]    rd_word;
    logic           rd_vld;
    logic           rd_lst;

    assign fill_last  = (wr_cnt == LAST_IDX);
    assign burst_last = (rd_cnt == LAST_IDX);
    assign gap_last   = (gap_cnt == GAP_LAST);

`ifdef LED_SEQ_ABS_EN
    assign rd_word = (rd_data == 16'h8000) ? 16'h7FFF :
                     (rd_data[15] ? 16'(~rd_data + 16'd1) : rd_data);
`else
    assign rd_word = rd_data;
`endif

    // Next-state and buffer strobes; a low enable overrides everything.
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: state_nxt = FILL;
                FILL: begin
                    if (smpl_vld) begin
                        wr_en = 1'b1;
                        if (fill_last) state_nxt = BURST;
                    end
                end
                BURST: begin
                    rd_en = 1'b1;
                    if (burst_last) state_nxt = GAP;
                end
                GAP: begin
                    if (gap_last) state_nxt = FILL;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register and per-state counters, all cleared on any state change or abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            gap_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (!en || (state_nxt != state)) begin
                wr_cnt  <= '0;
                rd_cnt  <= '0;
                gap_cnt <= '0;
            end else begin
                if (wr_en) wr_cnt <= wr_cnt + 1'b1;
                if (rd_en) rd_cnt <= rd_cnt + 1'b1;
                if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

    // Frame buffer: plain synchronous RAM with one cycle of read latency.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_cnt[IW-1:0]] <= smpl_in;
        rd_data <= mem[rd_cnt[IW-1:0]];
    end

    // Output stage: registers read data together with its burst window and last flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld     <= 1'b0;
            rd_lst     <= 1'b0;
            sequencing <= 1'b0;
            frm_done   <= 1'b0;
            smpl_out   <= 16'h0000;
        end else if (!en) begin
            rd_vld     <= 1'b0;
            rd_lst     <= 1'b0;
            sequencing <= 1'b0;
            frm_done   <= 1'b0;
        end else begin
            rd_vld     <= rd_en;
            rd_lst     <= rd_en && burst_last;
            sequencing <= rd_vld;
            frm_done   <= rd_lst;
            if (rd_vld) smpl_out <= rd_word;
        end
    end

    // Saturating count of strobes that arrive while the buffer is busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= 8'd0;
        end else if (smpl_vld && ((state == BURST) || (state == GAP)) && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_led_smpl_seq.sv
// tb_led_smpl_seq: randomized and directed bench for led_smpl_seq against a
// frame-level timeline model; a second default-size instance covers 1024-sample frames.
module tb_led_smpl_seq;

    localparam int BL  = 8;
    localparam int AWS = 3;
    localparam int GAP = 4;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        smpl_vld;
    logic [15:0] smpl_in;
    logic        sequencing;
    logic [15:0] smpl_out;
    logic        frm_done;
    logic [7:0]  drop_cnt;

    logic        big_en;
    logic        big_vld;
    logic [15:0] big_in;
    logic        big_vld_nxt;
    logic [15:0] big_in_nxt;
    logic        big_seq;
    logic [15:0] big_out;
    logic        big_done;
    logic [7:0]  big_drop;

    int n_vec = 0;
    int n_mis = 0;

    logic [15:0] frame_in  [BL];
    logic [15:0] frame_exp [BL];

    // Timeline model state
    int          m_phase;
    int          m_fn;
    int          m_edge;
    int          m_cap;
    int          m_drop;
    logic        m_seq;
    logic        m_done;
    logic [15:0] m_out;
    logic [15:0] m_fill  [BL];
    logic [15:0] m_frame [BL];

    led_smpl_seq #(.BURST_LEN(BL), .AW(AWS), .GAP_CYC(GAP)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .smpl_vld(smpl_vld), .smpl_in(smpl_in),
        .sequencing(sequencing), .smpl_out(smpl_out), .frm_done(frm_done), .drop_cnt(drop_cnt)
    );

    led_smpl_seq #(.BURST_LEN(1024), .AW(10), .GAP_CYC(4)) big_dut (
        .clk(clk), .rst_n(rst_n), .en(big_en), .smpl_vld(big_vld), .smpl_in(big_in),
        .sequencing(big_seq), .smpl_out(big_out), .frm_done(big_done), .drop_cnt(big_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rect(input logic [15:0] x);
`ifdef LED_SEQ_ABS_EN
        int v;
        v = $signed(x);
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return 16'(v);
`else
        return x;
`endif
    endfunction

    // Model: a frame captured on edge c is busy for edges c+1..c+BL+GAP and is
    // visible on the outputs after edges c+2..c+BL+1.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_fn    = 0;
            m_edge  = 0;
            m_cap   = -1;
            m_drop  = 0;
            m_seq   = 1'b0;
            m_done  = 1'b0;
            m_out   = 16'h0000;
        end else begin
            m_edge = m_edge + 1;
            if (m_phase == 2 && smpl_vld && m_drop < 255) m_drop = m_drop + 1;
            if (!en) begin
                m_phase = 0;
                m_cap   = -1;
            end else if (m_phase == 0) begin
                m_phase = 1;
                m_fn    = 0;
            end else if (m_phase == 1) begin
                if (smpl_vld) begin
                    m_fill[m_fn] = smpl_in;
                    m_fn = m_fn + 1;
                    if (m_fn == BL) begin
                        m_frame = m_fill;
                        m_cap   = m_edge;
                        m_phase = 2;
                    end
                end
            end else if (m_edge == m_cap + BL + GAP) begin
                m_phase = 1;
                m_fn    = 0;
            end
            if (en && m_cap >= 0 && m_edge >= m_cap + 2 && m_edge <= m_cap + BL + 1) begin
                m_seq  = 1'b1;
                m_out  = rect(m_frame[m_edge - m_cap - 2]);
                m_done = (m_edge == m_cap + BL + 1);
            end else begin
                m_seq  = 1'b0;
                m_done = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compareModel();
        checkOutput("model_seq",  {15'd0, sequencing}, {15'd0, m_seq});
        checkOutput("model_out",  smpl_out, m_out);
        checkOutput("model_done", {15'd0, frm_done}, {15'd0, m_done});
        checkOutput("model_drop", {8'd0, drop_cnt}, 16'(m_drop));
    endtask

    task automatic applyStimulus(input logic e, input logic v, input logic [15:0] d);
        @(posedge clk);
        #1;
        en       = e;
        smpl_vld = v;
        smpl_in  = d;
        big_vld  = big_vld_nxt;
        big_in   = big_in_nxt;
        @(negedge clk);
        compareModel();
    endtask

    task automatic feedFrame();
        for (int k = 0; k < BL; k++) begin
            repeat ($urandom_range(0, 2)) applyStimulus(1'b1, 1'b0, 16'($urandom));
            applyStimulus(1'b1, 1'b1, frame_in[k]);
        end
    endtask

    // Feeds frame_in and checks the burst against frame_exp; abort_at >= 0 drops en on that beat.
    task automatic runFrame(input int abort_at);
        bit aborted;
        aborted = 1'b0;
        feedFrame();
        applyStimulus(1'b1, 1'b0, 16'h0);
        applyStimulus(1'b1, 1'b0, 16'h0);
        for (int k = 0; k < BL; k++) begin
            applyStimulus((k == abort_at) ? 1'b0 : 1'b1, 1'b0, 16'h0);
            checkOutput("frm_seq",  {15'd0, sequencing}, 16'd1);
            checkOutput("frm_out",  smpl_out, frame_exp[k]);
            checkOutput("frm_done", {15'd0, frm_done}, 16'(k == BL - 1));
            if (k == abort_at) begin
                applyStimulus(1'b0, 1'b0, 16'h0);
                checkOutput("abort_seq",  {15'd0, sequencing}, 16'd0);
                checkOutput("abort_done", {15'd0, frm_done}, 16'd0);
                checkOutput("abort_hold", smpl_out, frame_exp[k]);
                aborted = 1'b1;
                break;
            end
        end
        if (!aborted) begin
            applyStimulus(1'b1, 1'b0, 16'h0);
            checkOutput("frm_seq_end", {15'd0, sequencing}, 16'd0);
            checkOutput("frm_done_end", {15'd0, frm_done}, 16'd0);
            repeat (4) applyStimulus(1'b1, 1'b0, 16'h0);
        end
    endtask

    initial begin
        int run;
        int first_at;
        int done_cnt;
        int done_pos;
        bit fin;

        rst_n       = 1'b0;
        en          = 1'b1;
        smpl_vld    = 1'b0;
        smpl_in     = 16'h0;
        big_en      = 1'b1;
        big_vld     = 1'b0;
        big_in      = 16'h0;
        big_vld_nxt = 1'b0;
        big_in_nxt  = 16'h0;

        $display("[TB] reset hold");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'($urandom), 16'($urandom));
            checkOutput("rst_seq",  {15'd0, sequencing}, 16'd0);
            checkOutput("rst_out",  smpl_out, 16'h0000);
            checkOutput("rst_done", {15'd0, frm_done}, 16'd0);
            checkOutput("rst_drop", {8'd0, drop_cnt}, 16'd0);
        end
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        smpl_vld = 1'b0;
        applyStimulus(1'b1, 1'b0, 16'h0);
        applyStimulus(1'b1, 1'b0, 16'h0);

        $display("[TB] basic frame 1..8");
        for (int k = 0; k < BL; k++) begin
            frame_in[k]  = 16'(k + 1);
            frame_exp[k] = 16'(k + 1);
        end
        runFrame(-1);

        $display("[TB] drop counting");
        for (int k = 0; k < BL; k++) frame_in[k] = 16'($urandom);
        feedFrame();
        repeat (BL + GAP) applyStimulus(1'b1, 1'b1, 16'($urandom));
        applyStimulus(1'b1, 1'b0, 16'h0);
        checkOutput("drop_12", {8'd0, drop_cnt}, 16'd12);
        for (int r = 0; r < 22; r++) begin
            for (int k = 0; k < BL; k++) frame_in[k] = 16'($urandom);
            feedFrame();
            repeat (BL + GAP) applyStimulus(1'b1, 1'b1, 16'($urandom));
            applyStimulus(1'b1, 1'b0, 16'h0);
        end
        checkOutput("drop_sat", {8'd0, drop_cnt}, 16'd255);

        $display("[TB] default-size frame");
        for (int i = 0; i < 1024; i++) begin
            big_vld_nxt = 1'b0;
            if ($urandom_range(0, 3) == 0) applyStimulus(1'b1, 1'b0, 16'h0);
            big_vld_nxt = 1'b1;
            big_in_nxt  = 16'd100;
            applyStimulus(1'b1, 1'b0, 16'h0);
        end
        big_vld_nxt = 1'b0;
        big_in_nxt  = 16'h0;
        run = 0; first_at = -1; done_cnt = 0; done_pos = -1; fin = 1'b0;
        for (int c = 1; c <= 1200 && !fin; c++) begin
            applyStimulus(1'b1, 1'b0, 16'h0);
            if (big_done) begin
                done_cnt++;
                done_pos = run + 1;
            end
            if (big_seq) begin
                if (run == 0) first_at = c;
                run++;
                checkOutput("big_out", big_out, 16'd100);
            end else if (run > 0) begin
                fin = 1'b1;
            end
        end
        checkOutput("big_fin",      {15'd0, fin}, 16'd1);
        checkOutput("big_first",    16'(first_at), 16'd3);
        checkOutput("big_run",      16'(run), 16'd1024);
        checkOutput("big_done_cnt", 16'(done_cnt), 16'd1);
        checkOutput("big_done_pos", 16'(done_pos), 16'd1024);
        checkOutput("big_drop",     {8'd0, big_drop}, 16'd0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1, 1'($urandom), 16'($urandom));
        end

        $display("[TB] abort and recover");
        applyStimulus(1'b0, 1'b0, 16'h0);
        applyStimulus(1'b0, 1'b0, 16'h0);
        applyStimulus(1'b1, 1'b0, 16'h0);
        applyStimulus(1'b1, 1'b0, 16'h0);
        for (int k = 0; k < BL; k++) begin
            frame_in[k]  = 16'(10 * (k + 1));
            frame_exp[k] = 16'(10 * (k + 1));
        end
        runFrame(2);
        applyStimulus(1'b1, 1'b0, 16'h0);
        applyStimulus(1'b1, 1'b0, 16'h0);
        for (int k = 0; k < BL; k++) begin
            frame_in[k]  = 16'(101 + k);
            frame_exp[k] = 16'(101 + k);
        end
        runFrame(-1);

        $display("[TB] rectify frame");
        frame_in[0] = 16'hFFFB;
        frame_in[1] = 16'h8000;
        frame_in[2] = 16'h0007;
        for (int k = 3; k < BL; k++) frame_in[k] = 16'(k - 2);
`ifdef LED_SEQ_ABS_EN
        frame_exp[0] = 16'h0005;
        frame_exp[1] = 16'h7FFF;
`else
        frame_exp[0] = 16'hFFFB;
        frame_exp[1] = 16'h8000;
`endif
        frame_exp[2] = 16'h0007;
        for (int k = 3; k < BL; k++) frame_exp[k] = 16'(k - 2);
        runFrame(-1);

        $display("[TB] reset mid-burst");
        for (int k = 0; k < BL; k++) frame_in[k] = 16'($urandom_range(1, 16'h7FFF));
        feedFrame();
        repeat (6) applyStimulus(1'b1, 1'b0, 16'h0);
        checkOutput("mid_seq_pre", {15'd0, sequencing}, 16'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_seq",  {15'd0, sequencing}, 16'd0);
        checkOutput("mid_rst_out",  smpl_out, 16'h0000);
        checkOutput("mid_rst_done", {15'd0, frm_done}, 16'd0);
        checkOutput("mid_rst_drop", {8'd0, drop_cnt}, 16'd0);
        compareModel();
        applyStimulus(1'b1, 1'b0, 16'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) applyStimulus(1'b1, 1'b0, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/led_smpl_seq.md
Name: led_smpl_seq

Overview:
- Feeds the LED averaging block with audio samples.
- Captures sporadic codec samples (one per smpl_vld strobe) into an internal frame buffer.
- Once a full frame is collected, streams it out back-to-back, one sample per clk, with sequencing held high for the whole burst, then idles for a guard gap.
- Sits between the codec/sample source and the LED averager; its sequencing/smpl_out pair is that averager's input interface.

Parameters:
- BURST_LEN, 1024, samples per frame and exact number of consecutive cycles sequencing is high; must be a power of 2, at most 2**AW.
- AW, 10, buffer address width.
- GAP_CYC, 4, minimum cycles sequencing stays low between bursts; must be at least 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  enable; low aborts any activity and returns to IDLE.
- smpl_vld  in  1  one-cycle strobe qualifying smpl_in.
- smpl_in  in  16  signed codec sample.
- sequencing  out  1  burst window to the averager, registered.
- smpl_out  out  16  sample to the averager, registered, aligned with sequencing.
- frm_done  out  1  one-cycle pulse on the last sequencing cycle of a burst.
- drop_cnt  out  8  saturating count of samples dropped outside FILL, registered.

Behaviour:
- Reset values: sequencing=0, smpl_out=16'h0000, frm_done=0, drop_cnt=0, state=IDLE, wr_cnt=0, rd_cnt=0. Buffer contents are don't-care.
- Buffer: BURST_LEN x 16 synchronous RAM; 1-cycle read latency.
- State machine: IDLE, FILL, BURST, GAP.
- IDLE: when en=1, go to FILL next cycle with wr_cnt=0.
- FILL:
  - Each smpl_vld=1 cycle writes smpl_in to address wr_cnt, then wr_cnt increments.
  - The write at wr_cnt=BURST_LEN-1 moves the state to BURST.
  - No bound on time in FILL.
- BURST:
  - rd_cnt issues addresses 0..BURST_LEN-1 on consecutive cycles.
  - Read data is registered into smpl_out with sequencing=1.
  - The first sequencing=1 cycle is exactly 2 clk after the edge that captured the final fill sample.
  - sequencing stays high for exactly BURST_LEN consecutive cycles with no gaps. Sample k of the frame appears on the k-th high cycle, k from 0.
  - frm_done=1 on the last high cycle only.
- GAP:
  - sequencing=0 for GAP_CYC cycles.
  - Then go to FILL with wr_cnt=0 if en=1, else to IDLE.
  - smpl_out holds its last value whenever sequencing=0.
- Drops:
  - smpl_vld=1 in BURST or GAP is discarded and drop_cnt increments, saturating at 255.
  - smpl_vld=1 in IDLE is ignored without counting.
  - drop_cnt clears only on reset.
- en deassert:
  - From any state, the next state is IDLE.
  - sequencing goes to 0 on the next edge and the partial burst is abandoned; the downstream averager sees sequencing fall.
  - frm_done is not pulsed for an aborted burst.
  - The partial frame is discarded; wr_cnt and rd_cnt clear.
- smpl_vld and the final write are simultaneous by definition: the write completes and the state advances.
- Counters are AW+1 bits internally so terminal-count compare does not wrap.
- Asynchronous reset mid-burst: all outputs return to reset values immediately.

Optional Feature:
- Macro: LED_SEQ_ABS_EN.
- Defined:
  - smpl_out carries the magnitude of the stored sample, |x|.
  - -32768 saturates to 32767.
  - Rectification happens in the read-data register stage; latency is unchanged.
- Undefined: smpl_out is the raw signed sample, passed through bit-exact.

Test Plan:
- Reset check: hold rst_n=0 with en=1 and random smpl_vld -> sequencing=0, smpl_out=0, frm_done=0, drop_cnt=0; IDLE is held until release.
- Basic frame: BURST_LEN=8, feed samples 1..8 with irregular smpl_vld spacing -> sequencing high exactly 8 cycles starting 2 clk after the 8th strobe; smpl_out=1..8 in order; frm_done only on the value-8 cycle; then at least 4 low cycles.
- Default size: BURST_LEN=1024, feed 1024 samples of value 100 -> exactly 1024 contiguous sequencing-high cycles with smpl_out=100 throughout.
- Drop counting: strobe smpl_vld every cycle during BURST and GAP (8+4 cycles at BURST_LEN=8, GAP_CYC=4) -> drop_cnt=12. Repeat to over 255 total drops -> drop_cnt saturates at 255.
- Abort: deassert en on the 3rd sequencing cycle -> sequencing=0 on the next edge, no frm_done, state IDLE. Re-enable and feed 8 new samples -> a clean full burst of the new samples.
- Rectify: feed -5, -32768, 7 with LED_SEQ_ABS_EN defined -> 5, 32767, 7. Without the macro -> 16'hFFFB, 16'h8000, 16'h0007.
